alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer_if.sv | 44 ++++
 rtl/alu_cmd_sequencer.sv | 118 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of command, ALU-side and response signals for alu_cmd_sequencer.
// The slave modport is the sequencer; the master modport is its environment
// (command source, external 4-bit ALU and response sink).
// Optional macro: ALU_SEQ_ZERO_FLAG_EN adds the rsp_zero signal.
interface alu_cmd_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_load;
   logic [2:0] cmd_op;
   logic [1:0] cmd_dst;
   logic [1:0] cmd_src_a;
   logic [1:0] cmd_src_b;
   logic [3:0] cmd_imm;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_sel;
   logic [3:0] alu_out;
   logic       alu_carry;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_data;
   logic       rsp_carry;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic       rsp_zero;
`endif

   modport master (
      output cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
      output alu_out, alu_carry, rsp_ready,
      input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry
`ifdef ALU_SEQ_ZERO_FLAG_EN
      , input rsp_zero
`endif
   );

   modport slave (
      input  cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
      input  alu_out, alu_carry, rsp_ready,
      output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry
`ifdef ALU_SEQ_ZERO_FLAG_EN
      , output rsp_zero
`endif
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts load / ALU commands, drives an external 4-bit ALU
// from a 4 x 4-bit internal register file, writes results back and returns
// them through a valid/ready response channel.
// Optional macro: ALU_SEQ_ZERO_FLAG_EN adds rsp_zero (rsp_data == 0).
module alu_cmd_sequencer (
   input  logic               clk,
   input  logic               rst,
   alu_cmd_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_rf [0:3];
   logic [3:0] r_alu_a;
   logic [3:0] r_alu_b;
   logic [2:0] r_alu_sel;
   logic [1:0] r_dst;
   logic [3:0] r_rsp_data;
   logic       r_rsp_carry;
   logic       w_accept;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic       r_rsp_zero;
`endif

   // Carry is only meaningful for add (000) and subtract (001).
   function automatic logic carry_mask(input logic [2:0] sel, input logic carry);
      return ((sel == 3'b000) || (sel == 3'b001)) ? carry : 1'b0;
   endfunction

   assign bus.cmd_ready = (r_state == IDLE) && !rst;
   assign w_accept      = bus.cmd_valid && bus.cmd_ready;
   assign bus.rsp_valid = (r_state == RESP);
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_carry = r_rsp_carry;
   assign bus.alu_a     = r_alu_a;
   assign bus.alu_b     = r_alu_b;
   assign bus.alu_sel   = r_alu_sel;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   assign bus.rsp_zero  = r_rsp_zero;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state: loads skip EXEC, ALU ops spend exactly one cycle there.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next = bus.cmd_load ? RESP : EXEC;
            end
         end
         EXEC:    w_next = RESP;
         RESP: begin
            if (bus.rsp_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Register file, operand latches and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            r_rf[i] <= '0;
         end
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_sel   <= '0;
         r_dst       <= '0;
         r_rsp_data  <= '0;
         r_rsp_carry <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
         r_rsp_zero  <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_dst <= bus.cmd_dst;
            if (bus.cmd_load) begin
               // Immediate lands in the register file right away; ALU outputs untouched.
               r_rf[bus.cmd_dst] <= bus.cmd_imm;
               r_rsp_data        <= bus.cmd_imm;
               r_rsp_carry       <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
               r_rsp_zero        <= (bus.cmd_imm == 4'h0);
`endif
            end else begin
               // Operands are captured here, so dst == src reads the pre-write value.
               r_alu_a   <= r_rf[bus.cmd_src_a];
               r_alu_b   <= r_rf[bus.cmd_src_b];
               r_alu_sel <= bus.cmd_op;
            end
         end
         if (r_state == EXEC) begin
            r_rf[r_dst] <= bus.alu_out;
            r_rsp_data  <= bus.alu_out;
            r_rsp_carry <= carry_mask(r_alu_sel, bus.alu_carry);
`ifdef ALU_SEQ_ZERO_FLAG_EN
            r_rsp_zero  <= (bus.alu_out == 4'h0);
`endif
         end
      end
   end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard testbench for alu_cmd_sequencer. Models the external ALU with
// op codes 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not, 110 shl,
// 111 shr; non-arithmetic ops return a nonzero carry so masking is visible.
module tb_alu_cmd_sequencer;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   int   cyc;

   alu_cmd_sequencer_if bus();

   alu_cmd_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [3:0] data;
      logic       carry;
      logic       zero;
      int         acc_cyc;
      int         lat;
   } exp_t;

   exp_t       sb_q[$];
   logic       seen;
   logic [3:0] last_a;
   logic [3:0] last_b;
   logic [2:0] last_sel;
   logic [4:0] alu_res;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // External ALU model.
   always_comb begin
      alu_res = '0;
      case (bus.alu_sel)
         3'b000:  alu_res = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
         3'b001:  alu_res = {(bus.alu_a < bus.alu_b), bus.alu_a - bus.alu_b};
         3'b010:  alu_res = {1'b1, bus.alu_a & bus.alu_b};
         3'b011:  alu_res = {1'b1, bus.alu_a | bus.alu_b};
         3'b100:  alu_res = {1'b1, bus.alu_a ^ bus.alu_b};
         3'b101:  alu_res = {1'b1, ~bus.alu_a};
         3'b110:  alu_res = {bus.alu_a[3], bus.alu_a << 1};
         default: alu_res = {bus.alu_a[0], bus.alu_a >> 1};
      endcase
   end
   assign bus.alu_out   = alu_res[3:0];
   assign bus.alu_carry = alu_res[4];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares every presented response against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && bus.rsp_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: got data %0h, expected no response (cycle %0d)",
                     bus.rsp_data, cyc);
         end else begin
            if (!seen) begin
               seen = 1'b1;
               check("rsp_latency", 8'(cyc - sb_q[0].acc_cyc), 8'(sb_q[0].lat));
            end
            check("rsp_data", {4'h0, bus.rsp_data}, {4'h0, sb_q[0].data});
            check("rsp_carry", {7'h0, bus.rsp_carry}, {7'h0, sb_q[0].carry});
`ifdef ALU_SEQ_ZERO_FLAG_EN
            check("rsp_zero", {7'h0, bus.rsp_zero}, {7'h0, sb_q[0].zero});
`endif
            if (bus.rsp_ready) begin
               void'(sb_q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   // Issue one command; returns on the negedge after the accepting edge.
   task automatic send(input logic ld, input logic [2:0] op, input logic [1:0] dst,
                       input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] imm,
                       input logic [3:0] ea, input logic [3:0] eb,
                       input logic [3:0] ed, input logic ec, input bit push);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_load  = ld;
      bus.cmd_op    = op;
      bus.cmd_dst   = dst;
      bus.cmd_src_a = sa;
      bus.cmd_src_b = sb;
      bus.cmd_imm   = imm;
      for (int k = 0; k < 20; k++) begin
         if (bus.cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL cmd_accept: got cmd_ready 0, expected 1 within 20 cycles");
         bus.cmd_valid = 1'b0;
         return;
      end
      e.data    = ed;
      e.carry   = ec;
      e.zero    = (ed == 4'h0);
      e.acc_cyc = cyc;
      e.lat     = ld ? 1 : 2;
      if (push) sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (!ld) begin
         last_a   = ea;
         last_b   = eb;
         last_sel = op;
      end
      check("alu_a", {4'h0, bus.alu_a}, {4'h0, last_a});
      check("alu_b", {4'h0, bus.alu_b}, {4'h0, last_b});
      check("alu_sel", {5'h0, bus.alu_sel}, {5'h0, last_sel});
   endtask

   task automatic load(input logic [1:0] dst, input logic [3:0] imm);
      send(1'b1, 3'b000, dst, 2'd0, 2'd0, imm, 4'h0, 4'h0, imm, 1'b0, 1'b1);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 50; k++) begin
         if (sb_q.size() == 0 && bus.rsp_valid === 1'b0) return;
         @(negedge clk);
      end
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: got %0d pending responses, expected 0 within 50 cycles",
               sb_q.size());
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_alu_a"}, {4'h0, bus.alu_a}, 8'h0);
      check({tag, "_alu_b"}, {4'h0, bus.alu_b}, 8'h0);
      check({tag, "_alu_sel"}, {5'h0, bus.alu_sel}, 8'h0);
      check({tag, "_rsp_valid"}, {7'h0, bus.rsp_valid}, 8'h0);
      check({tag, "_rsp_data"}, {4'h0, bus.rsp_data}, 8'h0);
      check({tag, "_rsp_carry"}, {7'h0, bus.rsp_carry}, 8'h0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
      check({tag, "_rsp_zero"}, {7'h0, bus.rsp_zero}, 8'h0);
`endif
      check({tag, "_cmd_ready"}, {7'h0, bus.cmd_ready}, 8'h1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      seen    = 1'b0;
      last_a  = 4'h0;
      last_b  = 4'h0;
      last_sel = 3'h0;
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_load  = 1'b0;
      bus.cmd_op    = 3'h0;
      bus.cmd_dst   = 2'h0;
      bus.cmd_src_a = 2'h0;
      bus.cmd_src_b = 2'h0;
      bus.cmd_imm   = 4'h0;
      bus.rsp_ready = 1'b1;

      // Reset: cmd_ready low while rst is high, reset values right after release.
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", {7'h0, bus.cmd_ready}, 8'h0);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");

      // 9 + 8 -> 1 with carry.
      load(2'd1, 4'h9);
      load(2'd2, 4'h8);
      send(1'b0, 3'b000, 2'd3, 2'd1, 2'd2, 4'h0, 4'h9, 4'h8, 4'h1, 1'b1, 1'b1);

      // 3 - 5 -> E with borrow, then (E & 5) -> 4 with carry masked.
      load(2'd1, 4'h3);
      load(2'd2, 4'h5);
      send(1'b0, 3'b001, 2'd0, 2'd1, 2'd2, 4'h0, 4'h3, 4'h5, 4'hE, 1'b1, 1'b1);
      send(1'b0, 3'b010, 2'd1, 2'd0, 2'd2, 4'h0, 4'hE, 4'h5, 4'h4, 1'b0, 1'b1);

      // dst == src: r1 = r1 + r1 = 8.
      send(1'b0, 3'b000, 2'd1, 2'd1, 2'd1, 4'h0, 4'h4, 4'h4, 4'h8, 1'b0, 1'b1);

      // Shifts: 9 << 1 -> 2, 2 >> 1 -> 1, carry masked both times.
      load(2'd1, 4'h9);
      send(1'b0, 3'b110, 2'd1, 2'd1, 2'd0, 4'h0, 4'h9, 4'hE, 4'h2, 1'b0, 1'b1);
      send(1'b0, 3'b111, 2'd1, 2'd1, 2'd0, 4'h0, 4'h2, 4'hE, 4'h1, 1'b0, 1'b1);

      // Back-pressure: response held 5 cycles, a pending command is ignored.
      wait_idle();
      bus.rsp_ready = 1'b0;
      load(2'd3, 4'h7);
      check("hold_rsp_valid0", {7'h0, bus.rsp_valid}, 8'h1);
      bus.cmd_valid = 1'b1;
      bus.cmd_load  = 1'b1;
      bus.cmd_dst   = 2'd0;
      bus.cmd_imm   = 4'hF;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_cmd_ready", {7'h0, bus.cmd_ready}, 8'h0);
         check("hold_rsp_valid", {7'h0, bus.rsp_valid}, 8'h1);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      // r0 must still be E: E + 7 = 0x15.
      send(1'b0, 3'b000, 2'd3, 2'd0, 2'd3, 4'h0, 4'hE, 4'h7, 4'h5, 1'b1, 1'b1);

      // Reset during EXEC of OR r1,r2 -> r2: no response, no write-back.
      load(2'd2, 4'h6);
      wait_idle();
      send(1'b0, 3'b011, 2'd2, 2'd1, 2'd2, 4'h0, 4'h1, 4'h6, 4'h7, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_a   = 4'h0;
      last_b   = 4'h0;
      last_sel = 3'h0;
      @(negedge clk);
      check_reset_outputs("abort");
      repeat (3) @(negedge clk);
      check("abort_rsp_valid", {7'h0, bus.rsp_valid}, 8'h0);
      // r2 reads 0 after the reset.
      send(1'b0, 3'b000, 2'd0, 2'd2, 2'd2, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);

`ifdef ALU_SEQ_ZERO_FLAG_EN
      // Zero flag: 5 ^ 5 -> 0, then a nonzero load.
      load(2'd1, 4'h5);
      send(1'b0, 3'b100, 2'd2, 2'd1, 2'd1, 4'h0, 4'h5, 4'h5, 4'h0, 1'b0, 1'b1);
      load(2'd3, 4'h7);
`endif

      wait_idle();
      check("sb_empty", 8'(sb_q.size()), 8'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
